// File: rtl/ifu_fold_pkg.sv
// Shared types and constants for the IFU instruction-folding scheduler.
//   fold_state_e   : scheduler FSM states (2-bit encoding)
//   fold_grp_t     : one folded group as seen by the folding decoder muxes
//   ONEHOT_DEFAULT : select value used when a byte-offset select is unused
//   onehot8()      : byte offset (0..7) to one-hot select
package ifu_fold_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StStall  = 2'd2,
    StStarve = 2'd3
  } fold_state_e;

  localparam logic [7:0]  ONEHOT_DEFAULT = 8'h01;
  localparam int unsigned MaxFold        = 4;
  localparam int unsigned IbufDepth      = 7;

  typedef struct packed {
    logic [7:0] accum_len0;
    logic [7:0] accum_len1;
    logic [7:0] accum_len2;
    logic [3:0] offset_rsd_ctl;
    logic [2:0] grp_fold;
    logic [2:0] grp_bytes;
  } fold_grp_t;

  // Group presented while nothing is issuing.
  localparam fold_grp_t GrpDefault = '{
    accum_len0:     ONEHOT_DEFAULT,
    accum_len1:     ONEHOT_DEFAULT,
    accum_len2:     ONEHOT_DEFAULT,
    offset_rsd_ctl: 4'b0001,
    grp_fold:       3'd1,
    grp_bytes:      3'd0
  };

  function automatic logic [7:0] onehot8(input logic [4:0] pos);
    return (pos < 5'd8) ? (8'h01 << pos[2:0]) : ONEHOT_DEFAULT;
  endfunction

endpackage

// File: rtl/fold_size_calc.sv
// Combinational fold-size selection for the folding decoder.
//   fetch_valid_i   : thermometer valid bits of ibuffer bytes 0..6
//   ilen0_i..3_i    : head instruction lengths (0 = not decodable)
//   fold_req_i      : requested group size (0 treated as 1, clamped to 4)
//   grp_o           : selected group (one-hot selects, fold size, byte count)
//   starve_o        : no instruction can issue from the current buffer
module fold_size_calc
  import ifu_fold_pkg::*;
(
  input  logic [6:0] fetch_valid_i,
  input  logic [2:0] ilen0_i,
  input  logic [2:0] ilen1_i,
  input  logic [2:0] ilen2_i,
  input  logic [2:0] ilen3_i,
  input  logic [2:0] fold_req_i,
  output fold_grp_t  grp_o,
  output logic       starve_o
);

  logic [2:0]       avail;
  logic [2:0]       req_lim;
  logic [3:0][2:0]  ilen;
  logic [3:0][4:0]  sum;
  logic [2:0]       k;
  logic [1:0]       kidx;
  logic             ok;

  always_comb begin
    avail = '0;
    for (int i = 0; i < int'(IbufDepth); i++) begin
      avail = avail + {2'b00, fetch_valid_i[i]};
    end

    if (fold_req_i == 3'd0) begin
      req_lim = 3'd1;
    end else if (fold_req_i > 3'(MaxFold)) begin
      req_lim = 3'(MaxFold);
    end else begin
      req_lim = fold_req_i;
    end

    ilen   = {ilen3_i, ilen2_i, ilen1_i, ilen0_i};
    sum[0] = {2'b00, ilen[0]};
    for (int j = 1; j < int'(MaxFold); j++) begin
      sum[j] = sum[j-1] + {2'b00, ilen[j]};
    end

    // Partial sums are monotonic, so the first failing position ends the group.
    k  = '0;
    ok = 1'b1;
    for (int j = 0; j < int'(MaxFold); j++) begin
      if (ok && (3'(j) < req_lim) && (ilen[j] != 3'd0) && (sum[j] <= {2'b00, avail})) begin
        k = 3'(j + 1);
      end else begin
        ok = 1'b0;
      end
    end
  end

  always_comb begin
    grp_o    = GrpDefault;
    starve_o = (k == 3'd0);
    kidx     = 2'(k - 3'd1);
    if (k != 3'd0) begin
      if (k >= 3'd2) grp_o.accum_len0 = onehot8(sum[0]);
      if (k >= 3'd3) grp_o.accum_len1 = onehot8(sum[1]);
      if (k == 3'd4) grp_o.accum_len2 = onehot8(sum[2]);
      grp_o.offset_rsd_ctl = 4'b0001 << kidx;
      grp_o.grp_fold       = k;
      grp_o.grp_bytes      = sum[kidx][2:0];
    end
  end

endmodule

// File: rtl/fold_sched_ctl.sv
// Folding decode scheduler: sequences issue of folded groups from the ibuffer head.
//   clk_i, rst_ni         : core clock, asynchronous active-low reset
//   fetch_valid_i, ilen*_i: ibuffer head state
//   fold_req_i            : requested group size from fold-pattern decode
//   iu_hold_i, iu_flush_i : IU back-pressure and pipeline redirect
//   grp_*_o, accum_len*_o, offset_rsd_ctl_o : presented group
//   ibuf_consume_o        : bytes shifted out of the ibuffer at this edge
//   perf_grp_o, perf_fold_o : saturating issue statistics
module fold_sched_ctl
  import ifu_fold_pkg::*;
#(
  parameter int unsigned FLUSH_BUBBLE = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [6:0]       fetch_valid_i,
  input  logic [2:0]       ilen0_i,
  input  logic [2:0]       ilen1_i,
  input  logic [2:0]       ilen2_i,
  input  logic [2:0]       ilen3_i,
  input  logic [2:0]       fold_req_i,
  input  logic             iu_hold_i,
  input  logic             iu_flush_i,
  output logic             grp_valid_o,
  output logic [7:0]       accum_len0_o,
  output logic [7:0]       accum_len1_o,
  output logic [7:0]       accum_len2_o,
  output logic [3:0]       offset_rsd_ctl_o,
  output logic [2:0]       grp_fold_o,
  output logic [2:0]       grp_bytes_o,
  output logic [2:0]       ibuf_consume_o,
  output logic [CNT_W-1:0] perf_grp_o,
  output logic [CNT_W-1:0] perf_fold_o
);

  localparam logic [1:0] BubbleInit = 2'(FLUSH_BUBBLE);

  fold_state_e      state_q, state_d;
  logic [1:0]       bubble_q, bubble_d;
  fold_grp_t        snap_q, snap_d;
  logic [CNT_W-1:0] perf_grp_q, perf_grp_d;
  logic [CNT_W-1:0] perf_fold_q, perf_fold_d;

  fold_grp_t calc_grp;
  logic      starve;
  fold_grp_t cur_grp;
  logic      valid;
  logic      consume_en;

  fold_size_calc u_calc (
    .fetch_valid_i (fetch_valid_i),
    .ilen0_i       (ilen0_i),
    .ilen1_i       (ilen1_i),
    .ilen2_i       (ilen2_i),
    .ilen3_i       (ilen3_i),
    .fold_req_i    (fold_req_i),
    .grp_o         (calc_grp),
    .starve_o      (starve)
  );

  // Presented group: live from the buffer head, or frozen while the IU holds.
  always_comb begin
    valid   = 1'b0;
    cur_grp = GrpDefault;
    unique case (state_q)
      StIdle: ;
      StRun, StStarve: begin
        if (!starve) begin
          valid   = 1'b1;
          cur_grp = calc_grp;
        end
      end
      StStall: begin
        valid   = 1'b1;
        cur_grp = snap_q;
      end
      default: ;
    endcase
    if (iu_flush_i) begin
      valid   = 1'b0;
      cur_grp = GrpDefault;
    end
    consume_en = valid && !iu_hold_i;
  end

  always_comb begin
    state_d     = state_q;
    bubble_d    = bubble_q;
    snap_d      = snap_q;
    perf_grp_d  = perf_grp_q;
    perf_fold_d = perf_fold_q;

    unique case (state_q)
      StIdle: begin
        // The last bubble cycle moves straight to RUN.
        if (bubble_q <= 2'd1) begin
          state_d  = StRun;
          bubble_d = 2'd0;
        end else begin
          bubble_d = bubble_q - 2'd1;
        end
      end
      StRun, StStarve: begin
        if (starve) begin
          state_d = StStarve;
        end else if (iu_hold_i) begin
          state_d = StStall;
          snap_d  = calc_grp;
        end else begin
          state_d = StRun;
        end
      end
      StStall: begin
        if (!iu_hold_i) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    if (iu_flush_i) begin
      state_d  = StIdle;
      bubble_d = BubbleInit;
      snap_d   = GrpDefault;
    end

    if (consume_en) begin
      if (!(&perf_grp_q)) perf_grp_d = perf_grp_q + 1'b1;
      if ((cur_grp.grp_fold > 3'd1) && !(&perf_fold_q)) perf_fold_d = perf_fold_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      bubble_q    <= BubbleInit;
      snap_q      <= GrpDefault;
      perf_grp_q  <= '0;
      perf_fold_q <= '0;
    end else begin
      state_q     <= state_d;
      bubble_q    <= bubble_d;
      snap_q      <= snap_d;
      perf_grp_q  <= perf_grp_d;
      perf_fold_q <= perf_fold_d;
    end
  end

  assign grp_valid_o      = valid;
  assign accum_len0_o     = cur_grp.accum_len0;
  assign accum_len1_o     = cur_grp.accum_len1;
  assign accum_len2_o     = cur_grp.accum_len2;
  assign offset_rsd_ctl_o = cur_grp.offset_rsd_ctl;
  assign grp_fold_o       = cur_grp.grp_fold;
  assign grp_bytes_o      = cur_grp.grp_bytes;
  assign ibuf_consume_o   = consume_en ? cur_grp.grp_bytes : 3'd0;
  assign perf_grp_o       = perf_grp_q;
  assign perf_fold_o      = perf_fold_q;

endmodule

// File: tb/tb_fold_sched_ctl.sv
// Bench for fold_sched_ctl: per-cycle comparison against a behavioural model
// plus directed literal expectations. Counters are narrowed to reach saturation.
module tb_fold_sched_ctl;

  localparam int FB   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_ni;
  logic [6:0]    fv;
  logic [2:0]    l0, l1, l2, l3;
  logic [2:0]    req;
  logic          hold, flush;
  logic          grp_valid;
  logic [7:0]    a0, a1, a2;
  logic [3:0]    off;
  logic [2:0]    gfold, gbytes, consume;
  logic [CW-1:0] pgrp, pfold;

  int n_checks = 0;
  int n_fail   = 0;

  fold_sched_ctl #(
    .FLUSH_BUBBLE (FB),
    .CNT_W        (CW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .fetch_valid_i    (fv),
    .ilen0_i          (l0),
    .ilen1_i          (l1),
    .ilen2_i          (l2),
    .ilen3_i          (l3),
    .fold_req_i       (req),
    .iu_hold_i        (hold),
    .iu_flush_i       (flush),
    .grp_valid_o      (grp_valid),
    .accum_len0_o     (a0),
    .accum_len1_o     (a1),
    .accum_len2_o     (a2),
    .offset_rsd_ctl_o (off),
    .grp_fold_o       (gfold),
    .grp_bytes_o      (gbytes),
    .ibuf_consume_o   (consume),
    .perf_grp_o       (pgrp),
    .perf_fold_o      (pfold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
               name, $time, act, act, exp, exp);
    end
  endtask

  typedef struct {
    bit         v;
    int         fold;
    int         bytes;
    logic [7:0] a0, a1, a2;
    logic [3:0] off;
  } grp_m_t;

  function automatic grp_m_t idle_grp();
    grp_m_t g;
    g.v = 1'b0; g.fold = 1; g.bytes = 0;
    g.a0 = 8'h01; g.a1 = 8'h01; g.a2 = 8'h01; g.off = 4'b0001;
    return g;
  endfunction

  // Largest prefix of head instructions that fits in the valid bytes.
  function automatic grp_m_t model_grp(input logic [6:0] v, input int i0, input int i1,
                                       input int i2, input int i3, input int r);
    grp_m_t g;
    int len[4];
    int sums[4];
    int avail, lim, k, s;
    len   = '{i0, i1, i2, i3};
    sums  = '{0, 0, 0, 0};
    avail = $countones(v);
    lim   = (r == 0) ? 1 : ((r > 4) ? 4 : r);
    k = 0;
    s = 0;
    for (int j = 0; j < lim; j++) begin
      if (len[j] == 0 || s + len[j] > avail) break;
      s       += len[j];
      sums[j] = s;
      k       = j + 1;
    end
    g = idle_grp();
    if (k > 0) begin
      g.v     = 1'b1;
      g.fold  = k;
      g.bytes = s;
      if (k >= 2) g.a0 = 8'(1 << sums[0]);
      if (k >= 3) g.a1 = 8'(1 << sums[1]);
      if (k == 4) g.a2 = 8'(1 << sums[2]);
      g.off = 4'(1 << (k - 1));
    end
    return g;
  endfunction

  // Model state: remaining bubble cycles, frozen group, expected counters.
  int     m_bub;
  bit     m_frz;
  grp_m_t m_snap;
  int     m_pg, m_pf;

  initial begin
    grp_m_t e;
    int     ec;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        m_bub = FB;
        m_frz = 1'b0;
        m_pg  = 0;
        m_pf  = 0;
      end else begin
        if (flush || m_bub > 0) e = idle_grp();
        else if (m_frz)         e = m_snap;
        else                    e = model_grp(fv, int'(l0), int'(l1), int'(l2), int'(l3),
                                              int'(req));
        ec = (e.v && !hold) ? e.bytes : 0;
        chk("grp_valid", int'(grp_valid), int'(e.v));
        chk("accum_len0", int'(a0), int'(e.a0));
        chk("accum_len1", int'(a1), int'(e.a1));
        chk("accum_len2", int'(a2), int'(e.a2));
        chk("offset_rsd_ctl", int'(off), int'(e.off));
        chk("grp_fold", int'(gfold), e.fold);
        chk("grp_bytes", int'(gbytes), e.bytes);
        chk("ibuf_consume", int'(consume), ec);
        chk("perf_grp", int'(pgrp), m_pg);
        chk("perf_fold", int'(pfold), m_pf);
        if (e.v && !hold) begin
          if (m_pg < CMAX) m_pg++;
          if (e.fold > 1 && m_pf < CMAX) m_pf++;
        end
        if (flush) begin
          m_bub = FB;
          m_frz = 1'b0;
        end else if (m_bub > 0) begin
          m_bub--;
        end else if (e.v && hold) begin
          m_snap = e;
          m_frz  = 1'b1;
        end else begin
          m_frz = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buf(input logic [6:0] v, input logic [2:0] i0, input logic [2:0] i1,
                         input logic [2:0] i2, input logic [2:0] i3, input logic [2:0] r);
    fv = v; l0 = i0; l1 = i1; l2 = i2; l3 = i3; req = r;
  endtask

  task automatic tvec(input logic [6:0] v, input logic [2:0] i0, input logic [2:0] i1,
                      input logic [2:0] i2, input logic [2:0] i3, input logic [2:0] r,
                      input int ev, input int ek, input int eb);
    step();
    set_buf(v, i0, i1, i2, i3, r);
    @(negedge clk);
    chk("vec_valid", int'(grp_valid), ev);
    chk("vec_fold", int'(gfold), ek);
    chk("vec_bytes", int'(gbytes), eb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    hold   = 1'b0;
    flush  = 1'b0;
    set_buf(7'h7F, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4);
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(grp_valid), 0);
    chk("rst_accum0", int'(a0), 8'h01);
    chk("rst_offset", int'(off), 1);
    chk("rst_fold", int'(gfold), 1);
    chk("rst_bytes", int'(gbytes), 0);
    chk("rst_consume", int'(consume), 0);
    chk("rst_perf", int'(pgrp), 0);

    step();
    rst_ni = 1'b1;
    @(negedge clk);
    chk("bubble1_valid", int'(grp_valid), 0);
    @(negedge clk);
    chk("bubble2_valid", int'(grp_valid), 0);

    // Full four-wide fold of single-byte instructions.
    @(negedge clk);
    chk("t1_valid", int'(grp_valid), 1);
    chk("t1_fold", int'(gfold), 4);
    chk("t1_accum0", int'(a0), 8'h02);
    chk("t1_accum1", int'(a1), 8'h04);
    chk("t1_accum2", int'(a2), 8'h08);
    chk("t1_offset", int'(off), 4'b1000);
    chk("t1_consume", int'(consume), 4);

    // Byte-limited fold.
    step();
    set_buf(7'h1F, 3'd3, 3'd2, 3'd3, 3'd1, 3'd3);
    @(negedge clk);
    chk("t2_fold", int'(gfold), 2);
    chk("t2_bytes", int'(gbytes), 5);
    chk("t2_accum0", int'(a0), 8'h08);
    chk("t2_accum1", int'(a1), 8'h01);
    chk("t2_offset", int'(off), 4'b0010);

    // Hold freezes the group while the buffer changes underneath.
    step();
    hold = 1'b1;
    @(negedge clk);
    chk("h0_consume", int'(consume), 0);
    chk("h0_bytes", int'(gbytes), 5);
    step();
    set_buf(7'h7F, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3);
    @(negedge clk);
    chk("h1_bytes", int'(gbytes), 5);
    chk("h1_accum0", int'(a0), 8'h08);
    chk("h1_consume", int'(consume), 0);
    step();
    set_buf(7'h7F, 3'd4, 3'd1, 3'd1, 3'd1, 3'd3);
    @(negedge clk);
    chk("h2_fold", int'(gfold), 2);
    chk("h2_consume", int'(consume), 0);
    step();
    hold = 1'b0;
    @(negedge clk);
    chk("hrel_consume", int'(consume), 5);
    chk("hrel_fold", int'(gfold), 2);
    step();
    @(negedge clk);
    chk("hnext_fold", int'(gfold), 3);
    chk("hnext_bytes", int'(gbytes), 6);

    // Starve, then recover in the same cycle the bytes arrive.
    step();
    set_buf(7'h03, 3'd3, 3'd2, 3'd2, 3'd2, 3'd4);
    @(negedge clk);
    chk("sv0_valid", int'(grp_valid), 0);
    step();
    @(negedge clk);
    chk("sv1_valid", int'(grp_valid), 0);
    step();
    fv = 7'h07;
    @(negedge clk);
    chk("sv2_valid", int'(grp_valid), 1);
    chk("sv2_fold", int'(gfold), 1);
    chk("sv2_bytes", int'(gbytes), 3);

    // Flush while stalled discards the snapshot and inserts bubbles.
    step();
    set_buf(7'h7F, 3'd2, 3'd2, 3'd1, 3'd1, 3'd4);
    hold = 1'b1;
    @(negedge clk);
    chk("fl0_bytes", int'(gbytes), 6);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("fl1_valid", int'(grp_valid), 0);
    chk("fl1_consume", int'(consume), 0);
    step();
    flush = 1'b0;
    hold  = 1'b0;
    set_buf(7'h03, 3'd1, 3'd1, 3'd0, 3'd0, 3'd4);
    @(negedge clk);
    chk("fl2_valid", int'(grp_valid), 0);
    step();
    @(negedge clk);
    chk("fl3_valid", int'(grp_valid), 0);
    step();
    @(negedge clk);
    chk("fl4_valid", int'(grp_valid), 1);
    chk("fl4_fold", int'(gfold), 2);
    chk("fl4_bytes", int'(gbytes), 2);

    // Boundary vectors.
    tvec(7'h7F, 3'd5, 3'd2, 3'd1, 3'd1, 3'd4, 1, 2, 7);
    tvec(7'h7F, 3'd1, 3'd1, 3'd0, 3'd1, 3'd4, 1, 2, 2);
    tvec(7'h7F, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 1, 1, 2);
    tvec(7'h0F, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 1, 4, 4);
    tvec(7'h00, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 0, 1, 0);
    tvec(7'h7F, 3'd0, 3'd1, 3'd1, 3'd1, 3'd4, 0, 1, 0);

    // Drive both counters into saturation.
    step();
    set_buf(7'h7F, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2);
    repeat (20) step();
    @(negedge clk);
    chk("sat_perf_grp", int'(pgrp), CMAX);
    chk("sat_perf_fold", int'(pfold), CMAX);
    repeat (3) step();
    @(negedge clk);
    chk("sat_hold_grp", int'(pgrp), CMAX);
    chk("sat_hold_fold", int'(pfold), CMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fold_sched_ctl.md
Name: fold_sched_ctl

Overview:
- Sequences the instruction-folding decode datapath in the IFU.
- Selects how many instructions (1..4) at the instruction-buffer head issue as one folded group, and drives the one-hot byte-offset selects (accum_len0/1/2) and the rsd-source select (offset_rsd_ctl) consumed by the folding decoder muxes.
- Freezes the issued group across IU holds, inserts bubbles after flushes, reports bytes consumed to the ibuffer, and keeps saturating issue statistics.

Parameters:
- FLUSH_BUBBLE, 2, cycles grp_valid is held low after a flush (1..3).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  core clock.
- reset_l  in  1  reset; asynchronous, active-low.
- fetch_valid  in  7  thermometer valid bits for ibuffer bytes 0..6; bit k set means byte k is valid.
- ilen0..ilen3  in  3 each  lengths of instructions 0..3 at the buffer head, range 1..5; 0 means not yet decodable.
- fold_req  in  3  group size requested by fold-pattern decode, 1..4; 0 is treated as 1.
- iu_hold  in  1  IU cannot accept a group this cycle.
- iu_flush  in  1  pipeline redirect; the buffer is being invalidated.
- grp_valid  out  1  a group is presented.
- accum_len0  out  8  one-hot start byte of instruction 1.
- accum_len1  out  8  one-hot start byte of instruction 2.
- accum_len2  out  8  one-hot start byte of instruction 3.
- offset_rsd_ctl  out  4  one-hot; selects which instruction (0..3) supplies the rsd offset.
- grp_fold  out  3  number of instructions in the presented group, 1..4.
- grp_bytes  out  3  total bytes of the presented group, 1..7.
- ibuf_consume  out  3  bytes the ibuffer shifts out at this edge.
- perf_grp  out  CNT_W  consumed groups, saturating.
- perf_fold  out  CNT_W  consumed groups with grp_fold>1, saturating.

Behaviour:
- Byte count: avail = number of set fetch_valid bits (0..7).
- Partial sums use 5-bit arithmetic, with no wrap:
  - s1 = ilen0
  - s2 = s1 + ilen1
  - s3 = s2 + ilen2
  - s4 = s3 + ilen3
- Fold size k = largest k <= max(fold_req,1) such that s_k <= avail and ilen0..ilen(k-1) are all nonzero.
- If no such k exists (ilen0 = 0 or s1 > avail), the buffer is starving.
- Combinational group selects:
  - accum_len0 = onehot(s1) when k>=2, else 8'h01.
  - accum_len1 = onehot(s2) when k>=3 and s2<=7, else 8'h01.
  - accum_len2 = onehot(s3) when k=4 and s3<=7, else 8'h01.
  - offset_rsd_ctl bit (k-1) set.
  - grp_fold = k.
  - grp_bytes = s_k.
- States: IDLE, RUN, STALL, STARVE.
- Reset (async): state=IDLE, bubble count=FLUSH_BUBBLE, grp_valid=0, accum_len0/1/2=8'h01, offset_rsd_ctl=4'b0001, grp_fold=1, grp_bytes=0, ibuf_consume=0, perf counters=0.
- IDLE:
  - grp_valid=0; the bubble counter decrements each cycle.
  - At 0, go to RUN.
- RUN:
  - If starving, go to STARVE with grp_valid=0 this cycle.
  - Otherwise grp_valid=1 and outputs are the combinational group.
  - If iu_hold=1, snapshot all group outputs into registers and go to STALL.
- STALL:
  - Outputs come from the snapshot; they are stable even if fetch_valid or ilen* change.
  - grp_valid=1.
  - When iu_hold drops, the snapshot is consumed this cycle and next state is RUN.
- STARVE:
  - grp_valid=0.
  - Re-evaluate each cycle; when not starving, go to RUN. A group may issue in the cycle of the transition (combinational).
- Consume: ibuf_consume = grp_bytes when grp_valid & !iu_hold, else 0.
  - The same condition increments perf_grp.
  - It also increments perf_fold when grp_fold>1.
  - Both counters saturate at all-ones.
- iu_flush:
  - Highest priority in every state, including STALL.
  - Same cycle: grp_valid=0 and ibuf_consume=0; the snapshot is discarded.
  - Next state IDLE with the bubble counter reloaded to FLUSH_BUBBLE.
- Flush during IDLE reloads the bubble counter.
- Flush and hold together: the flush wins.
- Latency: group outputs are combinational from the buffer head in RUN; a hold adds no latency beyond the hold itself.

Decomposition:
- Shared package ifu_fold_pkg holds:
  - state encoding (2 bits);
  - ONEHOT_DEFAULT = 8'h01;
  - the max fold size constant of 4;
  - the ibuffer depth constant of 7.
- One sub-module, fold_size_calc: purely combinational partial sums, k selection, one-hot generation and starve detection.
- fold_sched_ctl holds the FSM, snapshot registers and counters.

Test Plan:
- Reset, then fetch_valid=7'h7F, ilen=1,1,1,1, fold_req=4, no hold, after 2 bubble cycles:
  - grp_valid=1, grp_fold=4, accum_len0=8'h02, accum_len1=8'h04, accum_len2=8'h08, offset_rsd_ctl=4'b1000, ibuf_consume=4.
- Byte limit: ilen=3,2,3,1, fold_req=3, fetch_valid=7'h1F (avail=5):
  - k=2, grp_bytes=5, accum_len0=8'h08, accum_len1=8'h01, offset_rsd_ctl=4'b0010.
- Hold freeze: group issued, iu_hold=1 for 3 cycles while ilen/fetch_valid change:
  - Outputs are unchanged, ibuf_consume=0.
  - On release, consume equals the original grp_bytes and perf_grp increments by 1.
- Starve: ilen0=3, fetch_valid=7'h03:
  - STARVE, grp_valid=0.
  - Raising fetch_valid to 7'h07 gives grp_valid=1, grp_fold=1, grp_bytes=3 in the same cycle.
- Flush in STALL with iu_hold=1:
  - grp_valid=0 immediately, and for FLUSH_BUBBLE cycles after.
  - The snapshot is discarded; the next group reflects the new buffer contents.
- Counter saturation: preload near max (force), issue 3 folded groups:
  - perf_grp and perf_fold stick at all-ones.
